ro_meas_ctrl: RTL
=================

# ro_meas_ctrl

Measurement sequencer for the on-chip ring oscillators. On `start` it enables exactly one oscillator and waits a settle interval. It then counts synchronized rising edges of that oscillator's tap over a programmable gate window of `clk` cycles, and reports the count with a single-cycle `done`. It sits between the host-facing control registers and the oscillator bank, and replaces the free-running, switch-driven enable.

## Interface
- `N_RO`, 4: number of ring oscillators under control.
- `SEL_W`, $clog2(N_RO) (min 1): width of `ro_sel`.
- `GATE_W`, 16: width of `gate_cycles`.
- `CNT_W`, 16: width of `count`.
- `SETTLE_CYC`, 8: cycles `ro_en` is high before gating starts (≥1).

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request a measurement; sampled only in IDLE.
- `abort` input 1: cancel an in-progress measurement.
- `ro_sel` input SEL_W: oscillator index, latched on accepted `start`.
- `gate_cycles` input GATE_W: gate length in clk cycles, latched on accepted `start`.
- `ro_tap` input N_RO: oscillator taps, asynchronous to `clk`. Taps are pre-divided so that frequency is < clk/2.
- `ro_en` output N_RO: oscillator enables, at most one bit high (one-hot or zero).
- `busy` output 1: high from SETTLE through GATE.
- `done` output 1: one-cycle pulse when `count` is updated.
- `count` output CNT_W: last completed measurement; holds until next completion.
- `overflow` output 1: last measurement saturated.

## Operation
- FSM states: IDLE, SETTLE, GATE, DONE.
- IDLE:
  - `start`=1 and `ro_sel`<N_RO: latch `ro_sel` and `gate_cycles`, clear the edge counter, go to SETTLE.
  - `start`=1 and `ro_sel`≥N_RO: ignored; stay IDLE, no `busy`.
- SETTLE:
  - `ro_en[sel]`=1.
  - Down-counter runs SETTLE_CYC cycles, then go to GATE.
  - If latched `gate_cycles`==0, go directly to DONE instead.
- GATE:
  - `ro_en[sel]`=1.
  - Every synchronized rising edge of `ro_tap[sel]` increments the edge counter.
  - Runs `gate_cycles` cycles, then go to DONE.
- DONE:
  - Lasts one cycle.
  - `ro_en`=0, `done`=1.
  - `count` and `overflow` are loaded from the edge counter.
  - Next state is IDLE.
- Synchronization and edge detect:
  - Every tap passes through 2 flops, then a third flop for edge detect: rise = s2 & ~s3.
  - The selected rise is muxed after synchronization.
- Arithmetic: the edge counter is CNT_W bits and saturating. An increment at all-ones holds all-ones and sets the sticky internal overflow bit. Both are cleared on accepted `start`.
- `abort` in SETTLE or GATE:
  - Next state is IDLE and `ro_en`=0.
  - No `done`; `count` and `overflow` are unchanged.
  - `abort` in IDLE or DONE is ignored.
- `start` while busy or in DONE: ignored, not queued.
- `rst`: state IDLE; `ro_en`=0, `busy`=0, `done`=0, `count`=0, `overflow`=0; counters and synchronizer flops = 0.

## Timing
- `start` sampled high at edge 0 (IDLE).
  - Cycles 1..SETTLE_CYC: SETTLE, `busy`=1.
  - Next `gate_cycles` cycles: GATE.
  - Cycle 1+SETTLE_CYC+`gate_cycles`: DONE, `done`=1, new `count` visible the same cycle, `busy`=0.
- `ro_en` rises the cycle after accepted `start` and falls the first DONE cycle.
- Edge latency of 3 cycles is not compensated. The gate window is defined on synchronized edges, and tap activity in the last 3 GATE cycles may be dropped.
- A new `start` is accepted earliest in the cycle after DONE.
- `done` is never high for two consecutive cycles.

## Structure
- Package `ro_meas_pkg`: FSM state enum (IDLE, SETTLE, GATE, DONE) and default parameter constants.
- Sub-module `ro_sync_edge`:
  - Per-bit 2-flop synchronizer plus rise detector.
  - Instantiated once with width N_RO.
  - The FSM, counters and output registers live in `ro_meas_ctrl`.

## Test plan
- Nominal measurement:
  - Stimulus: SETTLE_CYC=8, `ro_sel`=2, `gate_cycles`=100, `ro_tap[2]` toggling with period 10 clk, other taps static.
  - Response: `ro_en`=4'b0100 cycles 1..108; `done` at cycle 109; `count`=10 (±1); `overflow`=0.
- Saturation:
  - Stimulus: CNT_W=4, tap period 4 clk, `gate_cycles`=100.
  - Response: `count`=15, `overflow`=1. A following measurement with the tap static gives `count`=0, `overflow`=0.
- Abort:
  - Stimulus: assert `abort` at cycle 50 of a 100-cycle gate.
  - Response: `ro_en`=0 and `busy`=0 next cycle; no `done`; `count` keeps its prior value.
- Reset mid-GATE:
  - Stimulus: `rst` at cycle 30.
  - Response: all outputs 0 next cycle. `start` two cycles later completes normally.
- Zero-length gate:
  - Stimulus: `gate_cycles`=0.
  - Response: `done` at cycle 1+SETTLE_CYC; `count`=0.
- Out-of-range select:
  - Stimulus: N_RO=3, `ro_sel`=3.
  - Response: `busy` never rises, `ro_en` stays 0, no `done`.

Source files
------------

// File: rtl/ro_meas_pkg.sv
// Shared types and defaults for the ring-oscillator measurement sequencer.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        GATE,
        DONE
    } state_t;

    localparam int N_RO_DEF       = 4;
    localparam int GATE_W_DEF     = 16;
    localparam int CNT_W_DEF      = 16;
    localparam int SETTLE_CYC_DEF = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Per-bit two-flop synchronizer followed by a rising-edge detector.
module ro_sync_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enable one oscillator, settle,
// count synchronized tap edges over a gate window, report with done.
module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int N_RO       = N_RO_DEF,
    parameter int SEL_W      = idx_width(N_RO),
    parameter int GATE_W     = GATE_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [SEL_W-1:0]  ro_sel,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [N_RO-1:0]   ro_tap,
    output logic [N_RO-1:0]   ro_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int SET_W = idx_width(SETTLE_CYC);
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYC - 1);

    state_t            state;
    logic [SEL_W-1:0]  sel_q;
    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] gate_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ovf_q;
    logic              ovf_nxt;
    logic [N_RO-1:0]   rise;
    logic              rise_sel;
    logic              sel_ok;

    ro_sync_edge #(
        .W(N_RO)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ro_tap),
        .rise(rise)
    );

    assign rise_sel = rise[sel_q];
    assign sel_ok   = 32'(ro_sel) < N_RO;

    // Saturating edge count including the rise seen this cycle.
    always_comb begin
        cnt_nxt = edge_cnt;
        ovf_nxt = ovf_q;
        if (state == GATE && rise_sel) begin
            if (&edge_cnt) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = edge_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_q      <= '0;
            gate_q     <= '0;
            gate_cnt   <= '0;
            settle_cnt <= '0;
            edge_cnt   <= '0;
            ovf_q      <= 1'b0;
            ro_en      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && sel_ok) begin
                        sel_q      <= ro_sel;
                        gate_q     <= gate_cycles;
                        settle_cnt <= SETTLE_LD;
                        edge_cnt   <= '0;
                        ovf_q      <= 1'b0;
                        ro_en      <= N_RO'(1) << ro_sel;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        ro_en <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end else if (gate_q != '0) begin
                        gate_cnt <= gate_q - 1'b1;
                        state    <= GATE;
                    end else begin
                        ro_en    <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        count    <= cnt_nxt;
                        overflow <= ovf_nxt;
                        state    <= DONE;
                    end
                end
                GATE: begin
                    if (abort) begin
                        ro_en <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        edge_cnt <= cnt_nxt;
                        ovf_q    <= ovf_nxt;
                        if (gate_cnt != '0) begin
                            gate_cnt <= gate_cnt - 1'b1;
                        end else begin
                            ro_en    <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            count    <= cnt_nxt;
                            overflow <= ovf_nxt;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
